path_store: RTL and testbench
=============================

PATH_STORE -- requirements
Module: path_store

Interface
REQ-001 SHALL have parameter MAX_NODES, default 16: node slots; MAX_NODES <= 2^INDEX_WIDTH - 1.
REQ-002 SHALL have parameter INDEX_WIDTH, default 5: node index width; the all-ones value is the UNVISITED sentinel.
REQ-003 SHALL have port clock  in  1  rising-edge clock for all state.
REQ-004 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have port init  in  1  start a new graph: clear the store and load node_count.
REQ-006 SHALL have port node_count  in  INDEX_WIDTH  node total; sampled only while init=1.
REQ-007 SHALL have port set_en / set_index / set_prev  in  1/INDEX_WIDTH/INDEX_WIDTH  mark set_index visited with predecessor set_prev.
REQ-008 SHALL have port rd_index  in  INDEX_WIDTH; rd_prev  out  INDEX_WIDTH  registered read port.
REQ-009 SHALL have port unvisited_nodes  out  INDEX_WIDTH; all_visited  out  1 (unvisited_nodes==0 and a graph is loaded).
REQ-010 SHALL have port prev_vector_flattened  out  INDEX_WIDTH*MAX_NODES; slot j occupies bits [INDEX_WIDTH*j +: INDEX_WIDTH].
REQ-011 SHALL have trace ports: trace_start, trace_target, trace_source (in); trace_node (INDEX_WIDTH), trace_valid, trace_last, trace_busy, trace_error (out); trace_ready (in).

Function
REQ-012 SHALL apply init at the clock edge: all slots := UNVISITED, unvisited_nodes := min(node_count, MAX_NODES), trace FSM := IDLE.
REQ-013 SHALL give init priority over set_en and trace_start in the same cycle; those are dropped.
REQ-014 SHALL, on set_en with set_index < unvisited-limit (loaded count) and slot == UNVISITED, write set_prev and decrement unvisited_nodes at that edge.
REQ-015 SHALL ignore set_en to an already-visited slot, out-of-range index, set_prev == UNVISITED, or while trace_busy=1; no counter change.
REQ-016 SHALL never underflow unvisited_nodes.
REQ-017 SHALL present rd_prev = slot[rd_index] one cycle after rd_index, reflecting writes from the previous edge; out-of-range -> UNVISITED.
REQ-018 SHALL update prev_vector_flattened and all_visited from registers the edge after the write.
REQ-019 SHALL implement trace FSM states IDLE, EMIT, ERR.
REQ-020 SHALL, in IDLE on trace_start: if slot[trace_target]==UNVISITED or target out of range -> ERR; else cur := target, steps := 0 -> EMIT; trace_busy=1 from next cycle.
REQ-021 SHALL, in EMIT, drive trace_valid=1, trace_node=cur, trace_last=(cur==trace_source latched at start); hold all three stable until trace_ready.
REQ-022 SHALL, on trace_valid&trace_ready: if trace_last -> IDLE; else nxt := slot[cur]; nxt==UNVISITED or steps==loaded_count-1 -> ERR; else cur := nxt, steps++ and remain EMIT (one node per cycle at full ready).
REQ-023 SHALL, in ERR, pulse trace_error for exactly one cycle with trace_valid=0, then return to IDLE.
REQ-024 SHALL ignore trace_start while trace_busy=1.

Reset
REQ-025 SHALL, with reset_n=0 at an edge: all slots UNVISITED, unvisited_nodes=0, all_visited=0, rd_prev=UNVISITED, FSM IDLE, trace_valid/last/busy/error=0, trace_node=0.
REQ-026 SHALL abort an in-progress trace on reset_n=0 or init with no trace_error pulse.

Configuration
REQ-027 SHALL honour macro PATH_STORE_TRACE_EN: defined -> trace FSM per REQ-019..024; undefined -> FSM absent, trace inputs ignored, all trace outputs constant 0, set_en never blocked by trace.

Verification
REQ-028 SHALL cover: reset_n=0 then init node_count=4 -> unvisited_nodes=4, all slots 31, all_visited=0.
REQ-029 SHALL cover: set (0,0),(1,0),(3,1),(2,3) -> unvisited_nodes 3,2,1,0; all_visited=1 after fourth write; repeat set (1,2) -> slot1 stays 0.
REQ-030 SHALL cover: same graph, trace target=2 source=0, ready=1 -> trace_node 2,3,1,0 on consecutive cycles, trace_last only on 0.
REQ-031 SHALL cover: trace with trace_ready toggling 0/1 -> each node held until accepted, no node skipped or duplicated.
REQ-032 SHALL cover: trace target unvisited, and cyclic prevs 1->2->1 with source 0 -> single trace_error pulse, no valid (first) / error after 3 emits (second).
REQ-033 SHALL cover: init and set_en same cycle -> store cleared, write lost; set_en during trace_busy -> ignored.

Source files
------------

// File: rtl/path_store.sv
// path_store: predecessor store for graph search, with an optional path trace
// walker enabled by defining PATH_STORE_TRACE_EN.
// Ports:
//   clock, reset_n (sync, active-low), init, node_count
//   set_en/set_index/set_prev: mark a node visited with its predecessor
//   rd_index -> rd_prev: registered slot read
//   unvisited_nodes, all_visited, prev_vector_flattened: store status
//   trace_start/target/source/ready in; trace_node/valid/last/busy/error out
module path_store #(
    parameter int MAX_NODES   = 16,
    parameter int INDEX_WIDTH = 5
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             init,
    input  logic [INDEX_WIDTH-1:0]           node_count,
    input  logic                             set_en,
    input  logic [INDEX_WIDTH-1:0]           set_index,
    input  logic [INDEX_WIDTH-1:0]           set_prev,
    input  logic [INDEX_WIDTH-1:0]           rd_index,
    output logic [INDEX_WIDTH-1:0]           rd_prev,
    output logic [INDEX_WIDTH-1:0]           unvisited_nodes,
    output logic                             all_visited,
    output logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened,
    input  logic                             trace_start,
    input  logic [INDEX_WIDTH-1:0]           trace_target,
    input  logic [INDEX_WIDTH-1:0]           trace_source,
    input  logic                             trace_ready,
    output logic [INDEX_WIDTH-1:0]           trace_node,
    output logic                             trace_valid,
    output logic                             trace_last,
    output logic                             trace_busy,
    output logic                             trace_error
);

    localparam logic [INDEX_WIDTH-1:0] LP_UNV = '1;
    localparam logic [INDEX_WIDTH-1:0] LP_MAX = INDEX_WIDTH'(MAX_NODES);
    localparam logic [INDEX_WIDTH-1:0] LP_ONE = INDEX_WIDTH'(1);

    logic [INDEX_WIDTH-1:0]           r_slot [MAX_NODES];
    logic [INDEX_WIDTH-1:0]           r_count;
    logic [INDEX_WIDTH-1:0]           r_unvisited;
    logic                             r_loaded;
    logic [INDEX_WIDTH-1:0]           r_rd_prev;
    logic [INDEX_WIDTH*MAX_NODES-1:0] w_flat;
    logic [INDEX_WIDTH-1:0]           w_load_cnt;
    logic [INDEX_WIDTH-1:0]           w_set_cur;
    logic                             w_set_ok;
    logic                             w_busy;

    // Slot lookup bounded by the loaded count; anything outside reads UNVISITED.
    function automatic logic [INDEX_WIDTH-1:0] f_sel(
        input logic [INDEX_WIDTH*MAX_NODES-1:0] vec,
        input logic [INDEX_WIDTH-1:0]           idx,
        input logic [INDEX_WIDTH-1:0]           lim
    );
        logic [INDEX_WIDTH-1:0] v;
        v = LP_UNV;
        for (int j = 0; j < MAX_NODES; j++) begin
            if (idx == INDEX_WIDTH'(j) && idx < lim) begin
                v = vec[INDEX_WIDTH*j +: INDEX_WIDTH];
            end
        end
        return v;
    endfunction

    always_comb begin
        w_flat = '0;
        for (int j = 0; j < MAX_NODES; j++) begin
            w_flat[INDEX_WIDTH*j +: INDEX_WIDTH] = r_slot[j];
        end
    end

    assign w_load_cnt = (node_count > LP_MAX) ? LP_MAX : node_count;
    assign w_set_cur  = f_sel(w_flat, set_index, r_count);
    assign w_set_ok   = set_en && !w_busy && (set_index < r_count)
                     && (w_set_cur == LP_UNV) && (set_prev != LP_UNV)
                     && (r_unvisited != '0);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int j = 0; j < MAX_NODES; j++) r_slot[j] <= LP_UNV;
            r_count     <= '0;
            r_unvisited <= '0;
            r_loaded    <= 1'b0;
            r_rd_prev   <= LP_UNV;
        end else begin
            r_rd_prev <= f_sel(w_flat, rd_index, r_count);
            if (init) begin
                for (int j = 0; j < MAX_NODES; j++) r_slot[j] <= LP_UNV;
                r_count     <= w_load_cnt;
                r_unvisited <= w_load_cnt;
                r_loaded    <= 1'b1;
            end else if (w_set_ok) begin
                for (int j = 0; j < MAX_NODES; j++) begin
                    if (set_index == INDEX_WIDTH'(j)) r_slot[j] <= set_prev;
                end
                r_unvisited <= r_unvisited - LP_ONE;
            end
        end
    end

    assign rd_prev               = r_rd_prev;
    assign unvisited_nodes       = r_unvisited;
    assign all_visited           = r_loaded && (r_unvisited == '0);
    assign prev_vector_flattened = w_flat;

`ifdef PATH_STORE_TRACE_EN
    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_ERR} state_t;

    state_t                 r_state, w_state_nxt;
    logic [INDEX_WIDTH-1:0] r_cur, w_cur_nxt;
    logic [INDEX_WIDTH-1:0] r_steps, w_steps_nxt;
    logic [INDEX_WIDTH-1:0] r_src, w_src_nxt;
    logic [INDEX_WIDTH-1:0] w_tgt_prev;
    logic [INDEX_WIDTH-1:0] w_cur_prev;

    assign w_tgt_prev = f_sel(w_flat, trace_target, r_count);
    assign w_cur_prev = f_sel(w_flat, r_cur, r_count);
    assign w_busy     = (r_state != S_IDLE);

    always_ff @(posedge clock) begin
        // init aborts a walk silently, same as reset
        if (!reset_n || init) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_steps <= '0;
            r_src   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_steps <= w_steps_nxt;
            r_src   <= w_src_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_steps_nxt = r_steps;
        w_src_nxt   = r_src;
        trace_valid = 1'b0;
        trace_node  = '0;
        trace_last  = 1'b0;
        trace_error = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (trace_start) begin
                    if (w_tgt_prev == LP_UNV) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_cur_nxt   = trace_target;
                        w_steps_nxt = '0;
                        w_src_nxt   = trace_source;
                        w_state_nxt = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                trace_valid = 1'b1;
                trace_node  = r_cur;
                trace_last  = (r_cur == r_src);
                if (trace_ready) begin
                    if (r_cur == r_src) begin
                        w_state_nxt = S_IDLE;
                    // broken chain, or more hops than nodes means a cycle
                    end else if (w_cur_prev == LP_UNV
                              || r_steps == r_count - LP_ONE) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_cur_nxt   = w_cur_prev;
                        w_steps_nxt = r_steps + LP_ONE;
                    end
                end
            end
            S_ERR: begin
                trace_error = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign trace_busy = w_busy;
`else
    logic w_unused_trace;

    assign w_unused_trace = ^{trace_start, trace_target,
                              trace_source, trace_ready};
    assign w_busy         = 1'b0;
    assign trace_node     = '0;
    assign trace_valid    = 1'b0;
    assign trace_last     = 1'b0;
    assign trace_busy     = 1'b0;
    assign trace_error    = 1'b0;
`endif

endmodule

// File: tb/tb_path_store.sv
// Self-checking bench for path_store; trace scenarios are exercised when
// PATH_STORE_TRACE_EN is defined, otherwise trace outputs must stay 0.
module tb_path_store;

    localparam int MN = 16;
    localparam int IW = 5;
    localparam logic [IW-1:0] UNV = 5'd31;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             reset_n, init, set_en, trace_start, trace_ready;
    logic [IW-1:0]    node_count, set_index, set_prev, rd_index;
    logic [IW-1:0]    trace_target, trace_source;
    logic [IW-1:0]    rd_prev, unvisited_nodes, trace_node;
    logic             all_visited, trace_valid, trace_last;
    logic             trace_busy, trace_error;
    logic [IW*MN-1:0] prev_vector_flattened;

    int n_checks = 0;
    int n_errors = 0;

    logic [IW-1:0] rd_q[$];
    logic [IW:0]   tr_q[$];

    path_store #(.MAX_NODES(MN), .INDEX_WIDTH(IW)) dut (
        .clock(clock), .reset_n(reset_n), .init(init),
        .node_count(node_count), .set_en(set_en),
        .set_index(set_index), .set_prev(set_prev),
        .rd_index(rd_index), .rd_prev(rd_prev),
        .unvisited_nodes(unvisited_nodes), .all_visited(all_visited),
        .prev_vector_flattened(prev_vector_flattened),
        .trace_start(trace_start), .trace_target(trace_target),
        .trace_source(trace_source), .trace_ready(trace_ready),
        .trace_node(trace_node), .trace_valid(trace_valid),
        .trace_last(trace_last), .trace_busy(trace_busy),
        .trace_error(trace_error)
    );

    function automatic logic [IW-1:0] slot(input int j);
        return prev_vector_flattened[IW*j +: IW];
    endfunction

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic do_init(input logic [IW-1:0] cnt);
        init = 1'b1; node_count = cnt;
        step;
        init = 1'b0;
    endtask

    task automatic do_set(input logic [IW-1:0] i, input logic [IW-1:0] p);
        set_en = 1'b1; set_index = i; set_prev = p;
        step;
        set_en = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; init = 1'b0; node_count = '0; set_en = 1'b0;
        set_index = '0; set_prev = '0; rd_index = '0; trace_start = 1'b0;
        trace_target = '0; trace_source = '0; trace_ready = 1'b0;
        step; step;
        n_checks++;
        if (unvisited_nodes !== 5'd0) begin
            n_errors++; $display("FAIL reset_unvisited got %0d exp 0", unvisited_nodes);
        end
        n_checks++;
        if (all_visited !== 1'b0) begin
            n_errors++; $display("FAIL reset_all_visited got %b exp 0", all_visited);
        end
        n_checks++;
        if (rd_prev !== UNV) begin
            n_errors++; $display("FAIL reset_rd_prev got %0d exp 31", rd_prev);
        end
        n_checks++;
        if (prev_vector_flattened !== {MN{UNV}}) begin
            n_errors++; $display("FAIL reset_slots got %h exp all 31", prev_vector_flattened);
        end
        n_checks++;
        if ({trace_valid, trace_last, trace_busy, trace_error, trace_node} !== '0) begin
            n_errors++;
            $display("FAIL reset_trace got v%b l%b b%b e%b n%0d exp 0",
                     trace_valid, trace_last, trace_busy, trace_error, trace_node);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_init;
        do_init(5'd4);
        n_checks++;
        if (unvisited_nodes !== 5'd4) begin
            n_errors++; $display("FAIL init_unvisited got %0d exp 4", unvisited_nodes);
        end
        n_checks++;
        if (all_visited !== 1'b0) begin
            n_errors++; $display("FAIL init_all_visited got %b exp 0", all_visited);
        end
        n_checks++;
        if (prev_vector_flattened !== {MN{UNV}}) begin
            n_errors++; $display("FAIL init_slots got %h exp all 31", prev_vector_flattened);
        end
    endtask

    task automatic test_set;
        int si[6]  = '{5, 0, 0, 1, 3, 2};
        int sp[6]  = '{0, 31, 0, 0, 1, 3};
        int eu[6]  = '{4, 4, 3, 2, 1, 0};
        int ri[7]  = '{0, 1, 2, 3, 4, 5, 20};
        int re[7]  = '{0, 0, 3, 1, 31, 31, 31};
        logic [IW-1:0] e;
        for (int k = 0; k < 6; k++) begin
            do_set(IW'(si[k]), IW'(sp[k]));
            n_checks++;
            if (unvisited_nodes !== IW'(eu[k])) begin
                n_errors++;
                $display("FAIL set_unvisited[%0d] got %0d exp %0d", k, unvisited_nodes, eu[k]);
            end
            n_checks++;
            if (all_visited !== (k == 5)) begin
                n_errors++;
                $display("FAIL set_all_visited[%0d] got %b exp %b", k, all_visited, k == 5);
            end
        end
        do_set(5'd1, 5'd2);
        n_checks++;
        if (slot(1) !== 5'd0 || unvisited_nodes !== 5'd0) begin
            n_errors++;
            $display("FAIL set_repeat got slot1=%0d unv=%0d exp 0/0", slot(1), unvisited_nodes);
        end
        for (int k = 0; k < 7; k++) begin
            rd_index = IW'(ri[k]);
            rd_q.push_back(IW'(re[k]));
            step;
            e = rd_q.pop_front();
            n_checks++;
            if (rd_prev !== e) begin
                n_errors++;
                $display("FAIL rd_prev[%0d] got %0d exp %0d", ri[k], rd_prev, e);
            end
        end
    endtask

    task automatic test_collision;
        init = 1'b1; node_count = 5'd4;
        set_en = 1'b1; set_index = 5'd0; set_prev = 5'd0;
        step;
        init = 1'b0; set_en = 1'b0;
        n_checks++;
        if (slot(0) !== UNV || unvisited_nodes !== 5'd4) begin
            n_errors++;
            $display("FAIL init_set_collision got slot0=%0d unv=%0d exp 31/4",
                     slot(0), unvisited_nodes);
        end
    endtask

    task automatic test_boundary;
        do_init(5'd20);
        n_checks++;
        if (unvisited_nodes !== 5'd16) begin
            n_errors++; $display("FAIL clamp_count got %0d exp 16", unvisited_nodes);
        end
        do_set(5'd15, 5'd0);
        do_set(5'd16, 5'd0);
        n_checks++;
        if (unvisited_nodes !== 5'd15 || slot(15) !== 5'd0) begin
            n_errors++;
            $display("FAIL edge_slots got unv=%0d slot15=%0d exp 15/0",
                     unvisited_nodes, slot(15));
        end
    endtask

`ifdef PATH_STORE_TRACE_EN
    task automatic load_chain;
        do_init(5'd4);
        do_set(5'd0, 5'd0); do_set(5'd1, 5'd0);
        do_set(5'd3, 5'd1); do_set(5'd2, 5'd3);
    endtask

    task automatic start_trace(input logic [IW-1:0] t, input logic [IW-1:0] s);
        trace_start = 1'b1; trace_target = t; trace_source = s;
        step;
        trace_start = 1'b0;
    endtask

    task automatic test_trace;
        int gaps = 0;
        logic [IW:0] e;
        load_chain;
        trace_ready = 1'b1;
        tr_q.push_back({1'b0, 5'd2}); tr_q.push_back({1'b0, 5'd3});
        tr_q.push_back({1'b0, 5'd1}); tr_q.push_back({1'b1, 5'd0});
        start_trace(5'd2, 5'd0);
        for (int c = 0; c < 10 && tr_q.size() > 0; c++) begin
            if (trace_valid) begin
                e = tr_q.pop_front();
                n_checks++;
                if ({trace_last, trace_node} !== e) begin
                    n_errors++;
                    $display("FAIL trace_node got n%0d l%b exp n%0d l%b",
                             trace_node, trace_last, e[IW-1:0], e[IW]);
                end
            end else gaps++;
            step;
        end
        n_checks++;
        if (gaps != 0 || tr_q.size() != 0 || trace_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL trace_stream got gaps=%0d left=%0d busy=%b exp 0/0/0",
                     gaps, tr_q.size(), trace_busy);
        end
    endtask

    task automatic test_trace_stall;
        logic [IW:0] e;
        tr_q.push_back({1'b0, 5'd2}); tr_q.push_back({1'b0, 5'd3});
        tr_q.push_back({1'b0, 5'd1}); tr_q.push_back({1'b1, 5'd0});
        trace_ready = 1'b0;
        start_trace(5'd2, 5'd0);
        for (int c = 0; c < 30 && tr_q.size() > 0; c++) begin
            trace_ready = c[0];
            n_checks++;
            if (!trace_valid || {trace_last, trace_node} !== tr_q[0]) begin
                n_errors++;
                $display("FAIL stall_node[%0d] got v%b n%0d l%b exp n%0d l%b", c,
                         trace_valid, trace_node, trace_last, tr_q[0][IW-1:0], tr_q[0][IW]);
            end
            if (trace_ready) e = tr_q.pop_front();
            step;
        end
        trace_ready = 1'b1;
        n_checks++;
        if (tr_q.size() != 0 || trace_valid !== 1'b0 || trace_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_end got left=%0d v=%b busy=%b exp 0/0/0",
                     tr_q.size(), trace_valid, trace_busy);
        end
    endtask

    task automatic test_trace_error;
        int errs, vals;
        logic [IW:0] e;
        int tg[2] = '{0, 7};
        do_init(5'd3);
        do_set(5'd1, 5'd2); do_set(5'd2, 5'd1);
        trace_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            errs = 0; vals = 0;
            start_trace(IW'(tg[k]), 5'd0);
            for (int c = 0; c < 4; c++) begin
                errs += int'(trace_error);
                vals += int'(trace_valid);
                step;
            end
            n_checks++;
            if (errs != 1 || vals != 0) begin
                n_errors++;
                $display("FAIL bad_target[%0d] got err=%0d valid=%0d exp 1/0", tg[k], errs, vals);
            end
        end
        tr_q.push_back({1'b0, 5'd1}); tr_q.push_back({1'b0, 5'd2});
        tr_q.push_back({1'b0, 5'd1});
        trace_ready = 1'b0;
        start_trace(5'd1, 5'd0);
        do_set(5'd0, 5'd1);
        n_checks++;
        if (unvisited_nodes !== 5'd1 || slot(0) !== UNV) begin
            n_errors++;
            $display("FAIL set_while_busy got unv=%0d slot0=%0d exp 1/31",
                     unvisited_nodes, slot(0));
        end
        trace_ready = 1'b1;
        errs = 0;
        for (int c = 0; c < 10; c++) begin
            if (trace_valid) begin
                if (tr_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL cycle_extra got node %0d exp none", trace_node);
                end else begin
                    e = tr_q.pop_front();
                    n_checks++;
                    if ({trace_last, trace_node} !== e) begin
                        n_errors++;
                        $display("FAIL cycle_node got n%0d l%b exp n%0d l%b",
                                 trace_node, trace_last, e[IW-1:0], e[IW]);
                    end
                end
            end
            errs += int'(trace_error);
            step;
        end
        n_checks++;
        if (errs != 1 || tr_q.size() != 0 || trace_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL cycle_error got err=%0d left=%0d busy=%b exp 1/0/0",
                     errs, tr_q.size(), trace_busy);
        end
        do_set(5'd0, 5'd1);
        n_checks++;
        if (unvisited_nodes !== 5'd0) begin
            n_errors++; $display("FAIL set_after_trace got %0d exp 0", unvisited_nodes);
        end
    endtask

    task automatic test_init_abort;
        int errs = 0;
        trace_ready = 1'b0;
        start_trace(5'd2, 5'd0);
        n_checks++;
        if (trace_busy !== 1'b1) begin
            n_errors++; $display("FAIL abort_busy got %b exp 1", trace_busy);
        end
        do_init(5'd3);
        for (int c = 0; c < 3; c++) begin
            errs += int'(trace_error) + int'(trace_busy) + int'(trace_valid);
            step;
        end
        n_checks++;
        if (errs != 0) begin
            n_errors++; $display("FAIL abort_quiet got %0d active cycles exp 0", errs);
        end
        trace_ready = 1'b1;
    endtask
`else
    task automatic test_trace_disabled;
        int act = 0;
        trace_start = 1'b1; trace_target = 5'd0; trace_ready = 1'b1;
        set_en = 1'b1; set_index = 5'd0; set_prev = 5'd0;
        step;
        trace_start = 1'b0; set_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            act += int'(trace_valid) + int'(trace_busy) + int'(trace_error)
                 + int'(trace_last) + int'(trace_node != 0);
            step;
        end
        n_checks++;
        if (act != 0) begin
            n_errors++; $display("FAIL trace_disabled got %0d active outputs exp 0", act);
        end
        n_checks++;
        if (unvisited_nodes !== 5'd3) begin
            n_errors++; $display("FAIL set_not_blocked got %0d exp 3", unvisited_nodes);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_init;
        test_set;
`ifdef PATH_STORE_TRACE_EN
        test_trace;
        test_trace_stall;
`endif
        test_collision;
`ifndef PATH_STORE_TRACE_EN
        test_trace_disabled;
`endif
        test_boundary;
`ifdef PATH_STORE_TRACE_EN
        test_trace_error;
        test_init_abort;
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
